pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 57 +++++
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle.
// master: pipeline side. It drives the stage status, the forwarding sources, the redirect sources
//         and the icache ack, and it receives the operands, stall/clear and the redirect target.
// slave : the hazard controller. It sees the same signals with the directions reversed.
// Forwarding sources are packed, with source i at [i*W +: W]. Index 0 is the youngest source.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FWD_STAGES = 2
);
    logic                         id_valid;
    logic                         ex_valid;
    logic [4:0]                   id_rs1;
    logic [4:0]                   id_rs2;
    logic [XLEN-1:0]              id_rs1_value;
    logic [XLEN-1:0]              id_rs2_value;
    logic [4:0]                   ex_rd;
    logic                         ex_mem_ren;
    logic [FWD_STAGES-1:0]        fwd_valid;
    logic [FWD_STAGES-1:0]        fwd_wen;
    logic [5*FWD_STAGES-1:0]      fwd_rd;
    logic [XLEN*FWD_STAGES-1:0]   fwd_data;
    logic                         mem_rvalid;
    logic                         branch_flag;
    logic                         jump_flag;
    logic                         mret_flag;
    logic                         ecall_flag;
    logic                         fence_i_flag;
    logic [XLEN-1:0]              ex_result;
    logic [XLEN-1:0]              branch_pc;
    logic [XLEN-1:0]              fence_pc;
    logic [XLEN-1:0]              mepc;
    logic [XLEN-1:0]              mtvec;
    logic                         icache_clr_ack;
    logic                         icache_clr_req;
    logic [XLEN-1:0]              ex_rs1_in;
    logic [XLEN-1:0]              ex_rs2_in;
    logic                         ifu_stall;
    logic                         ex_inst_clear;
    logic                         dnpc_flag;
    logic [XLEN-1:0]              dnpc;

    modport master (
        output id_valid, ex_valid, id_rs1, id_rs2, id_rs1_value, id_rs2_value, ex_rd, ex_mem_ren,
               fwd_valid, fwd_wen, fwd_rd, fwd_data, mem_rvalid, branch_flag, jump_flag,
               mret_flag, ecall_flag, fence_i_flag, ex_result, branch_pc, fence_pc, mepc,
               mtvec, icache_clr_ack,
        input  icache_clr_req, ex_rs1_in, ex_rs2_in, ifu_stall, ex_inst_clear, dnpc_flag, dnpc
    );

    modport slave (
        input  id_valid, ex_valid, id_rs1, id_rs2, id_rs1_value, id_rs2_value, ex_rd, ex_mem_ren,
               fwd_valid, fwd_wen, fwd_rd, fwd_data, mem_rvalid, branch_flag, jump_flag,
               mret_flag, ecall_flag, fence_i_flag, ex_result, branch_pc, fence_pc, mepc,
               mtvec, icache_clr_ack,
        output icache_clr_req, ex_rs1_in, ex_rs2_in, ifu_stall, ex_inst_clear, dnpc_flag, dnpc
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller. It handles four jobs:
// - Operand forwarding from FWD_STAGES downstream sources. The youngest matching source wins.
// - Load-use stall. The pipeline holds until the load data returns.
// - Redirects: taken branch, jump, mret, ecall and fence_i. Each one drives dnpc/dnpc_flag and
//   clears EX for FLUSH_CYCLES cycles.
// - fence_i icache invalidate handshake (icache_clr_req/icache_clr_ack).
// Ports:
//   clock - rising-edge clock.
//   reset - asynchronous, active-low. While it is low, every control output is 0.
//   bus   - pipe_hazard_ctrl_if.slave, which carries all of the pipeline signals.
// Outputs depend on the current state and the current inputs. A redirect or a load-use is
// therefore signalled in the same cycle that it is seen.
module pipe_hazard_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FWD_STAGES   = 2,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StLdWait, StFlush, StFenceWait} state_e;

    localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);

    state_e          state_q;
    logic [2:0]      cnt_q;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            taken;
    logic            redirect;
    logic            fence_ev;
    logic            load_use;

    // Walk from the oldest source to the youngest, so that the lowest matching index is the
    // one that ends up in the result.
    always_comb begin
        rs1_fwd = bus.id_rs1_value;
        rs2_fwd = bus.id_rs2_value;
        for (int i = int'(FWD_STAGES) - 1; i >= 0; i--) begin
            if (bus.fwd_valid[i] && bus.fwd_wen[i]) begin
                if (bus.id_rs1 != 5'd0 && bus.fwd_rd[i*5 +: 5] == bus.id_rs1) begin
                    rs1_fwd = bus.fwd_data[i*XLEN +: XLEN];
                end
                if (bus.id_rs2 != 5'd0 && bus.fwd_rd[i*5 +: 5] == bus.id_rs2) begin
                    rs2_fwd = bus.fwd_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    assign bus.ex_rs1_in = rs1_fwd;
    assign bus.ex_rs2_in = rs2_fwd;

    assign taken    = bus.branch_flag & bus.ex_result[0];
    assign redirect = bus.ex_valid & (taken | bus.jump_flag | bus.mret_flag | bus.ecall_flag |
                                      bus.fence_i_flag);
    assign fence_ev = bus.ex_valid & bus.fence_i_flag;
    assign load_use = bus.ex_valid & bus.ex_mem_ren & (bus.ex_rd != 5'd0) & bus.id_valid &
                      ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2));

    // The target is meaningful only while dnpc_flag is high. The fall-through case is ecall.
    always_comb begin
        if (bus.jump_flag) begin
            bus.dnpc = bus.ex_result;
        end else if (taken) begin
            bus.dnpc = bus.branch_pc;
        end else if (bus.mret_flag) begin
            bus.dnpc = bus.mepc;
        end else if (bus.fence_i_flag) begin
            bus.dnpc = bus.fence_pc;
        end else begin
            bus.dnpc = bus.mtvec;
        end
    end

    // Gating with reset keeps every control output low for as long as reset is held. This holds
    // even when the inputs present a redirect to the idle state.
    always_comb begin
        bus.icache_clr_req = 1'b0;
        bus.ifu_stall      = 1'b0;
        bus.ex_inst_clear  = 1'b0;
        bus.dnpc_flag      = 1'b0;
        if (reset) begin
            unique case (state_q)
                StIdle: begin
                    if (redirect) begin
                        bus.dnpc_flag     = 1'b1;
                        bus.ex_inst_clear = 1'b1;
                    end else if (load_use) begin
                        bus.ifu_stall     = 1'b1;
                        bus.ex_inst_clear = 1'b1;
                    end
                end
                StLdWait: begin
                    bus.ifu_stall     = ~bus.mem_rvalid;
                    bus.ex_inst_clear = ~bus.mem_rvalid;
                end
                StFlush: begin
                    bus.ex_inst_clear = 1'b1;
                end
                StFenceWait: begin
                    bus.icache_clr_req = 1'b1;
                    bus.ifu_stall      = 1'b1;
                    bus.ex_inst_clear  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    // A redirect takes priority over a load-use. The load is being squashed anyway.
                    if (redirect) begin
                        if (fence_ev) begin
                            state_q <= StFenceWait;
                        end else if (FLUSH_CYCLES > 1) begin
                            state_q <= StFlush;
                            cnt_q   <= FlushInit;
                        end
                    end else if (load_use) begin
                        state_q <= StLdWait;
                    end
                end
                StLdWait: begin
                    if (bus.mem_rvalid) begin
                        state_q <= StIdle;
                    end
                end
                StFlush: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_q <= StIdle;
                        cnt_q   <= 3'd0;
                    end
                end
                StFenceWait: begin
                    if (bus.icache_clr_ack) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. It runs directed scenarios and then random traffic,
// and checks the DUT against a reference model kept as counters and flags.
module tb_pipe_hazard_ctrl;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NF   = 3;
    localparam int unsigned FC   = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipe_hazard_ctrl_if #(.XLEN(XLEN), .FWD_STAGES(NF)) bus ();

    pipe_hazard_ctrl #(.XLEN(XLEN), .FWD_STAGES(NF), .FLUSH_CYCLES(FC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: cycles of EX clear left, plus waiting-for-load and waiting-for-ack flags.
    int m_flush = 0;
    bit m_ld    = 1'b0;
    bit m_fence = 1'b0;

    // DUT outputs as observed by the most recent step.
    logic            obs_stall, obs_clr, obs_flag, obs_req;
    logic [XLEN-1:0] obs_dnpc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [XLEN-1:0] fwd_ref(input logic [4:0] rs, input logic [XLEN-1:0] rf);
        if (rs == 5'd0) return rf;
        for (int i = 0; i < int'(NF); i++) begin
            if (bus.fwd_valid[i] && bus.fwd_wen[i] && bus.fwd_rd[i*5 +: 5] == rs)
                return bus.fwd_data[i*XLEN +: XLEN];
        end
        return rf;
    endfunction

    function automatic logic [XLEN-1:0] dnpc_ref();
        if (bus.jump_flag) return bus.ex_result;
        if (bus.branch_flag && bus.ex_result[0]) return bus.branch_pc;
        if (bus.mret_flag) return bus.mepc;
        if (bus.fence_i_flag) return bus.fence_pc;
        return bus.mtvec;
    endfunction

    task automatic clear_inputs();
        bus.id_valid = 0; bus.ex_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.id_rs1_value = 32'h1234; bus.id_rs2_value = 32'h5678; bus.ex_rd = 0;
        bus.ex_mem_ren = 0; bus.fwd_valid = 0; bus.fwd_wen = 0; bus.fwd_rd = 0; bus.fwd_data = 0;
        bus.mem_rvalid = 0; bus.branch_flag = 0; bus.jump_flag = 0; bus.mret_flag = 0;
        bus.ecall_flag = 0; bus.fence_i_flag = 0; bus.ex_result = 0;
        bus.branch_pc = 32'h8000_0040; bus.fence_pc = 32'h8000_0100; bus.mepc = 32'h8000_0200;
        bus.mtvec = 32'h8000_0300; bus.icache_clr_ack = 0;
    endtask

    // Inputs are driven before the call. The step checks the outputs mid-cycle, advances one
    // clock edge and updates the model, and returns 1 time unit after the edge.
    task automatic step();
        bit redir, lu, e_flag, e_clr, e_stall, e_req, n_ld, n_fence;
        int n_flush;
        #2;
        redir = bus.ex_valid && ((bus.branch_flag && bus.ex_result[0]) || bus.jump_flag ||
                                 bus.mret_flag || bus.ecall_flag || bus.fence_i_flag);
        lu = bus.ex_valid && bus.ex_mem_ren && bus.ex_rd != 0 && bus.id_valid &&
             (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
        {e_flag, e_clr, e_stall, e_req} = 4'b0;
        n_flush = m_flush; n_ld = m_ld; n_fence = m_fence;
        if (!reset) begin
            n_flush = 0; n_ld = 0; n_fence = 0;
        end else if (m_fence) begin
            {e_req, e_stall, e_clr} = 3'b111;
            if (bus.icache_clr_ack) n_fence = 0;
        end else if (m_ld) begin
            e_stall = !bus.mem_rvalid; e_clr = !bus.mem_rvalid;
            if (bus.mem_rvalid) n_ld = 0;
        end else if (m_flush > 0) begin
            e_clr = 1; n_flush = m_flush - 1;
        end else if (redir) begin
            e_flag = 1; e_clr = 1;
            if (bus.fence_i_flag) n_fence = 1;
            else n_flush = int'(FC) - 1;
        end else if (lu) begin
            e_stall = 1; e_clr = 1; n_ld = 1;
        end
        obs_stall = bus.ifu_stall; obs_clr = bus.ex_inst_clear; obs_flag = bus.dnpc_flag;
        obs_req = bus.icache_clr_req; obs_dnpc = bus.dnpc;
        check("ifu_stall", 64'(obs_stall), 64'(e_stall));
        check("ex_inst_clear", 64'(obs_clr), 64'(e_clr));
        check("dnpc_flag", 64'(obs_flag), 64'(e_flag));
        check("icache_clr_req", 64'(obs_req), 64'(e_req));
        check("ex_rs1_in", 64'(bus.ex_rs1_in), 64'(fwd_ref(bus.id_rs1, bus.id_rs1_value)));
        check("ex_rs2_in", 64'(bus.ex_rs2_in), 64'(fwd_ref(bus.id_rs2, bus.id_rs2_value)));
        if (e_flag) check("dnpc", 64'(obs_dnpc), 64'(dnpc_ref()));
        @(posedge clock);
        m_flush = n_flush; m_ld = n_ld; m_fence = n_fence;
        #1;
    endtask

    task automatic drive_random();
        int r;
        bus.id_valid     = $urandom_range(0, 3) != 0;
        bus.ex_valid     = $urandom_range(0, 7) != 0;
        bus.id_rs1       = 5'($urandom_range(0, 7));
        bus.id_rs2       = 5'($urandom_range(0, 7));
        bus.id_rs1_value = $urandom;
        bus.id_rs2_value = $urandom;
        bus.ex_rd        = 5'($urandom_range(0, 7));
        bus.ex_mem_ren   = $urandom_range(0, 3) == 0;
        for (int i = 0; i < int'(NF); i++) begin
            bus.fwd_valid[i]            = 1'($urandom_range(0, 1));
            bus.fwd_wen[i]              = 1'($urandom_range(0, 1));
            bus.fwd_rd[i*5 +: 5]        = 5'($urandom_range(0, 7));
            bus.fwd_data[i*XLEN +: XLEN] = $urandom;
        end
        bus.mem_rvalid     = $urandom_range(0, 3) == 0;
        bus.icache_clr_ack = $urandom_range(0, 3) == 0;
        bus.ex_result = $urandom; bus.branch_pc = $urandom; bus.fence_pc = $urandom;
        bus.mepc = $urandom; bus.mtvec = $urandom;
        r = $urandom_range(0, 15);
        bus.fence_i_flag = r == 0;
        bus.branch_flag  = r != 0 && $urandom_range(0, 4) == 0;
        bus.jump_flag    = r != 0 && $urandom_range(0, 9) == 0;
        bus.mret_flag    = r != 0 && $urandom_range(0, 11) == 0;
        bus.ecall_flag   = r != 0 && $urandom_range(0, 11) == 0;
    endtask

    initial begin
        int cnt_a, cnt_b;
        clear_inputs();
        #1 reset = 1'b0;
        // A redirect is presented while reset is held, so every control output must stay low.
        bus.ex_valid = 1; bus.jump_flag = 1;
        step();
        step();
        reset = 1'b1;
        clear_inputs();
        step();

        // Forwarding priority: sources 0 and 1 both target x5.
        bus.fwd_valid = 3'b011; bus.fwd_wen = 3'b011;
        bus.fwd_rd = {5'd0, 5'd5, 5'd5}; bus.fwd_data = {32'h0, 32'hB, 32'hA};
        bus.id_rs1 = 5; bus.id_rs2 = 5;
        step();
        check("fwd_prio", 64'(bus.ex_rs1_in), 64'h0000_000A);
        bus.id_rs1 = 0;
        step();
        check("fwd_x0", 64'(bus.ex_rs1_in), 64'h1234);
        clear_inputs();

        // Load-use on rs2. The data returns on the 4th cycle after detection.
        bus.ex_valid = 1; bus.ex_mem_ren = 1; bus.ex_rd = 3; bus.id_valid = 1; bus.id_rs2 = 3;
        cnt_a = 0;
        step(); cnt_a += int'(obs_stall);
        bus.ex_valid = 0; bus.ex_mem_ren = 0;
        for (int i = 0; i < 3; i++) begin step(); cnt_a += int'(obs_stall); end
        bus.mem_rvalid = 1;
        step(); cnt_a += int'(obs_stall);
        bus.mem_rvalid = 0;
        step(); cnt_a += int'(obs_stall);
        check("ld_stall_cycles", 64'(cnt_a), 64'd4);
        clear_inputs();

        // Taken branch with a 3-cycle flush.
        bus.ex_valid = 1; bus.branch_flag = 1; bus.ex_result = 1;
        cnt_a = 0; cnt_b = 0;
        step(); cnt_a += int'(obs_flag); cnt_b += int'(obs_clr);
        check("branch_dnpc", 64'(obs_dnpc), 64'h8000_0040);
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            step(); cnt_a += int'(obs_flag); cnt_b += int'(obs_clr);
        end
        check("branch_flag_cycles", 64'(cnt_a), 64'd1);
        check("branch_clear_cycles", 64'(cnt_b), 64'd3);

        // fence_i: 5 wait cycles without ack, then ack on the 6th cycle.
        bus.ex_valid = 1; bus.fence_i_flag = 1;
        cnt_a = 0;
        step(); cnt_a += int'(obs_req);
        check("fence_dnpc", 64'(obs_dnpc), 64'h8000_0100);
        clear_inputs();
        for (int i = 0; i < 5; i++) begin step(); cnt_a += int'(obs_req); end
        bus.icache_clr_ack = 1;
        step(); cnt_a += int'(obs_req);
        bus.icache_clr_ack = 0;
        step(); cnt_a += int'(obs_req);
        check("fence_stall_after_ack", 64'(obs_stall), 64'd0);
        check("fence_req_cycles", 64'(cnt_a), 64'd6);

        // A jump arrives together with a load-use hazard. The jump wins and LD_WAIT is never
        // entered.
        bus.ex_valid = 1; bus.jump_flag = 1; bus.ex_result = 32'h100; bus.branch_flag = 1;
        bus.ex_mem_ren = 1; bus.ex_rd = 4; bus.id_valid = 1; bus.id_rs1 = 4;
        cnt_a = 0;
        step(); cnt_a += int'(obs_stall);
        check("jump_dnpc", 64'(obs_dnpc), 64'h100);
        clear_inputs();
        for (int i = 0; i < 4; i++) begin step(); cnt_a += int'(obs_stall); end
        check("jump_no_ldwait", 64'(cnt_a), 64'd0);

        // Reset asserted asynchronously during FENCE_WAIT.
        bus.ex_valid = 1; bus.fence_i_flag = 1;
        step();
        clear_inputs();
        step();
        check("fence_wait_req", 64'(obs_req), 64'd1);
        reset = 1'b0;
        #1;
        check("rst_req_async", 64'(bus.icache_clr_req), 64'd0);
        check("rst_stall_async", 64'(bus.ifu_stall), 64'd0);
        step();
        reset = 1'b1;
        bus.ex_valid = 1; bus.ex_mem_ren = 1; bus.ex_rd = 7; bus.id_valid = 1; bus.id_rs1 = 7;
        step();
        check("idle_after_reset", 64'(obs_stall), 64'd1);
        bus.ex_valid = 0;
        bus.mem_rvalid = 1;
        step();
        clear_inputs();

        // Random traffic, with an occasional reset pulse.
        for (int n = 0; n < 3000; n++) begin
            drive_random();
            if ($urandom_range(0, 299) == 0) reset = 1'b0;
            step();
            reset = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
